alu_issue_ctrl: RTL

Byte-serial instruction issue controller that drives the 8-bit ALU and latches its results. It accepts opcode and optional immediate bytes over a valid/ready stream, and decodes them. It sources operands from an internal 4×8 register file, presents operation/x/y to the ALU, and writes the ALU result and flags back. It is the consumer that closes the ALU's "alu latch" path toward the datapath.

---
 rtl/alu_issue_ctrl_if.sv | 13 +
 rtl/alu_issue_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Byte stream that carries opcode and immediate bytes into the issue controller.
// Handshake: a byte moves on a rising clock edge where instr_valid && instr_ready
// are both high. The master holds instr_byte stable while instr_valid is high and
// not yet accepted. instr_ready may be high with instr_valid low, and instr_valid
// may be deasserted between bytes at any time.
interface alu_issue_ctrl_if;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr_byte;

   modport master (output instr_valid, output instr_byte, input instr_ready);
   modport slave  (input instr_valid, input instr_byte, output instr_ready);
endinterface

// File: rtl/alu_issue_ctrl.sv
// Byte-serial issue controller: decodes opcode/immediate bytes, issues
// operation and operands to an external 8-bit ALU from a 4x8 register file,
// and writes the ALU result and flags back on the closing edge of EXEC.
module alu_issue_ctrl (
   input  logic             clock,
   input  logic             reset,
   alu_issue_ctrl_if.slave  instr,
   output logic [3:0]       alu_op,
   output logic [7:0]       alu_x,
   output logic [7:0]       alu_y,
   input  logic [15:0]      alu_out,
   output logic [3:0]       flags,
   input  logic [1:0]       rd_sel,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             wb_valid,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FETCH_IMM = 2'd1,
      EXEC      = 2'd2,
      ILLEGAL   = 2'd3
   } state_t;

   localparam logic [3:0] OP_CM  = 4'd4;
   localparam logic [3:0] OP_CMI = 4'd5;

   state_t     state;
   logic       ready_q;
   logic [3:0] op_q;
   logic [1:0] dst_q;
   logic [7:0] regs [0:3];

   // Field decode of the byte currently on the stream.
   logic [3:0] op_in;
   logic [1:0] dst_in;
   logic [1:0] src_in;
   logic       accept;
   logic       op_illegal;
   logic       op_is_imm;

   assign op_in      = instr.instr_byte[7:4];
   assign dst_in     = instr.instr_byte[3:2];
   assign src_in     = instr.instr_byte[1:0];
   assign accept     = instr.instr_valid && ready_q;
   assign op_illegal = (op_in >= 4'd12);
   assign op_is_imm  = op_in[0];

   assign instr.instr_ready = ready_q;
   assign rd_data           = regs[rd_sel];
   assign fsm_state         = state;

   // Only data and carry bits of the ALU result are consumed.
   logic unused_alu_hi;
   assign unused_alu_hi = ^alu_out[15:9];

   // Issue FSM with registered ready/busy, operand registers, register file and flags.
   // The immediate is captured straight into the operand register it feeds, so
   // the register-file read and the immediate land together on the edge into EXEC.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         ready_q  <= 1'b1;
         busy     <= 1'b0;
         op_q     <= 4'd0;
         dst_q    <= 2'd0;
         alu_op   <= 4'd0;
         alu_x    <= 8'd0;
         alu_y    <= 8'd0;
         flags    <= 4'd0;
         wb_valid <= 1'b0;
         for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q  <= op_in;
                  dst_q <= dst_in;
                  busy  <= 1'b1;
                  if (op_illegal) begin
                     state   <= ILLEGAL;
                     ready_q <= 1'b0;
                  end else if (op_is_imm) begin
                     state   <= FETCH_IMM;
                     ready_q <= 1'b1;
                  end else begin
                     // Register form: operands read now, before any writeback.
                     state   <= EXEC;
                     ready_q <= 1'b0;
                     alu_op  <= op_in;
                     alu_x   <= (op_in == OP_CM) ? regs[src_in] : regs[dst_in];
                     alu_y   <= (op_in == OP_CM) ? 8'd0 : regs[src_in];
                  end
               end
            end
            FETCH_IMM: begin
               if (accept) begin
                  state   <= EXEC;
                  ready_q <= 1'b0;
                  alu_op  <= op_q;
                  alu_x   <= (op_q == OP_CMI) ? instr.instr_byte : regs[dst_q];
                  alu_y   <= (op_q == OP_CMI) ? 8'd0 : instr.instr_byte;
               end
            end
            EXEC: begin
               regs[dst_q] <= alu_out[7:0];
               flags[0]    <= (op_q <= 4'd3) ? alu_out[8] : 1'b0;
               flags[1]    <= (alu_out[7:0] == 8'd0);
               flags[2]    <= alu_out[7];
               wb_valid    <= 1'b1;
               state       <= IDLE;
               ready_q     <= 1'b1;
               busy        <= 1'b0;
            end
            ILLEGAL: begin
               flags[3] <= 1'b1;
               state    <= IDLE;
               ready_q  <= 1'b1;
               busy     <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
